// File: rtl/divider_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow finish without iterating.
module divider_unit #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_start,
  input  logic                  i_kill,
  input  logic [1:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MinNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e                state_q, state_d;
  logic                  rem_sel_q, rem_sel_d;
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0] quot_q, quot_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;

  logic                  accept, signed_op, a_neg, b_neg, div_zero, overflow, no_borrow;
  logic [DATA_WIDTH-1:0] a_mag, b_mag, special_res, rem_nx, quot_nx, quot_fin, rem_fin;
  logic [DATA_WIDTH:0]   rem_sh, diff;

  always_comb begin
    accept      = (state_q == StIdle) && i_start && !i_kill;
    signed_op   = ~i_op[0];
    a_neg       = signed_op & i_dividend[DATA_WIDTH-1];
    b_neg       = signed_op & i_divisor[DATA_WIDTH-1];
    a_mag       = a_neg ? -i_dividend : i_dividend;
    b_mag       = b_neg ? -i_divisor : i_divisor;
    div_zero    = (i_divisor == '0);
    overflow    = signed_op && (i_dividend == MinNeg) && (i_divisor == '1);
    // Remainder of a divide-by-zero is the raw dividend, never its magnitude.
    if (div_zero) special_res = i_op[1] ? i_dividend : '1;
    else          special_res = i_op[1] ? '0 : i_dividend;

    // Trial subtract is one bit wider than the data so the borrow is visible.
    rem_sh    = {rem_q, quot_q[DATA_WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs_q};
    no_borrow = ~diff[DATA_WIDTH];
    rem_nx    = no_borrow ? diff[DATA_WIDTH-1:0] : rem_sh[DATA_WIDTH-1:0];
    quot_nx   = {quot_q[DATA_WIDTH-2:0], no_borrow};
    quot_fin  = neg_quot_q ? -quot_nx : quot_nx;
    rem_fin   = neg_rem_q ? -rem_nx : rem_nx;
  end

  always_comb begin
    state_d    = state_q;
    rem_sel_d  = rem_sel_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dvs_d      = dvs_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          rem_sel_d  = i_op[1];
          neg_quot_d = a_neg ^ b_neg;
          neg_rem_d  = a_neg;
          dvs_d      = b_mag;
          quot_d     = a_mag;
          rem_d      = '0;
          cnt_d      = '0;
          if (div_zero || overflow) begin
            state_d  = StDone;
            result_d = special_res;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (i_kill) begin
          state_d = StIdle;
        end else begin
          rem_d  = rem_nx;
          quot_d = quot_nx;
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            state_d  = StDone;
            result_d = rem_sel_q ? rem_fin : quot_fin;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= StIdle;
      rem_sel_q  <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dvs_q      <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      rem_sel_q  <= rem_sel_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dvs_q      <= dvs_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
    end
  end

  assign o_busy   = (state_q != StIdle);
  assign o_done   = (state_q == StDone) && !i_kill;
  assign o_result = result_q;

endmodule
